qei_decoder: RTL and testbench



---
 rtl/qei_decoder.sv | 251 +++++++++++++++++++++++++
 tb/tb_qei_decoder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qei_decoder.sv
// qei_decoder: quadrature encoder front end.
// Synchronizes and filters the A/B(/Z) pins, decodes quadrature steps into a
// wrapping position count, estimates velocity over a fixed window and
// captures the position on an index pulse.
// Optional build macro QEI_INDEX_EN: when defined, the Z pin path and index
// capture are built; otherwise enc_z/index_reset are ignored and the index
// outputs are tied to zero.
module qei_decoder #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FILT_LEN   = 4,
  parameter int unsigned VEL_W      = 16,
  parameter int unsigned VEL_PERIOD = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    enc_z,
  input  logic                    clr,
  input  logic                    err_clr,
  input  logic                    index_reset,
  output logic [CNT_W-1:0]        position,
  output logic                    dir,
  output logic                    err,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid,
  output logic [CNT_W-1:0]        index_pos,
  output logic                    index_valid
);

  localparam int unsigned FC_W      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int unsigned WIN_W     = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;
  localparam int unsigned ACC_MIN_W = $clog2(VEL_PERIOD + 1) + 1;
  localparam int unsigned ACC_W     = (ACC_MIN_W > VEL_W + 1) ? ACC_MIN_W : VEL_W + 1;
`ifdef QEI_INDEX_EN
  localparam int unsigned NPIN      = 3;
`else
  localparam int unsigned NPIN      = 2;
`endif
  localparam logic signed [ACC_W-1:0] VEL_MAX = ACC_W'((64'd1 << (VEL_W - 1)) - 64'd1);
  localparam logic signed [ACC_W-1:0] VEL_MIN = -VEL_MAX;

  // Start-up sequencing: two edges to fill the synchronizer, one to prime the filter
  typedef enum logic [1:0] {
    ST_SYNC1,
    ST_SYNC2,
    ST_PRIME,
    ST_RUN
  } state_t;

  state_t state_q, state_d;

  // Pin order: bit 0 = A, bit 1 = B, bit 2 = Z (index build only)
  logic [NPIN-1:0] pins_raw;
  logic [NPIN-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [NPIN-1:0] filt_q, filt_d, prev_q, prev_d;
  logic [FC_W-1:0] fcnt_q [NPIN];
  logic [FC_W-1:0] fcnt_d [NPIN];

  logic [CNT_W-1:0]        position_q, position_d, pos_step_c;
  logic                    dir_q, dir_d;
  logic                    err_q, err_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum_c, step_c;
  logic signed [VEL_W-1:0] velocity_q, velocity_d;
  logic                    vel_valid_q, vel_valid_d;

  logic       run_c, step_fwd_c, step_rev_c, illegal_c;
  logic [1:0] ab_prev_c, ab_cur_c;

`ifdef QEI_INDEX_EN
  logic [CNT_W-1:0] index_pos_q, index_pos_d;
  logic             index_valid_q, index_valid_d;
  logic             z_rise_c;
  assign pins_raw = {enc_z, enc_b, enc_a};
`else
  logic unused_pins;
  assign unused_pins = enc_z ^ index_reset;
  assign pins_raw    = {enc_b, enc_a};
`endif

  // Next {A,B} state one forward step along 00->10->11->01->00
  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    logic [1:0] nxt;
    unique case (ab)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // Synchronizer, per-pin glitch filter and start-up sequencer
  always_comb begin
    state_d = state_q;
    s1_d    = pins_raw;
    s2_d    = s1_q;
    filt_d  = filt_q;
    prev_d  = filt_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      ST_SYNC1: state_d = ST_SYNC2;
      ST_SYNC2: state_d = ST_PRIME;
      ST_PRIME: begin
        state_d = ST_RUN;
        filt_d  = s2_q;
        prev_d  = s2_q;
      end
      ST_RUN: begin
        for (int i = 0; i < int'(NPIN); i++) begin
          if (s2_q[i] != filt_q[i]) begin
            if (fcnt_q[i] == FC_W'(FILT_LEN - 1)) begin
              filt_d[i] = s2_q[i];
              fcnt_d[i] = '0;
            end else begin
              fcnt_d[i] = fcnt_q[i] + FC_W'(1);
            end
          end else begin
            fcnt_d[i] = '0;
          end
        end
      end
      default: state_d = ST_SYNC1;
    endcase
  end

  // Step decode from the previous and current filtered {A,B}
  always_comb begin
    run_c      = (state_q == ST_RUN);
    ab_prev_c  = {prev_q[0], prev_q[1]};
    ab_cur_c   = {filt_q[0], filt_q[1]};
    step_fwd_c = run_c && (ab_cur_c == fwd_next(ab_prev_c));
    step_rev_c = run_c && (ab_prev_c == fwd_next(ab_cur_c));
    illegal_c  = run_c && ((ab_cur_c ^ ab_prev_c) == 2'b11);
  end

  // Position, direction, error, velocity window and index capture
  always_comb begin
    position_d  = position_q;
    dir_d       = dir_q;
    err_d       = err_q;
    win_d       = win_q + WIN_W'(1);
    acc_d       = acc_q;
    velocity_d  = velocity_q;
    vel_valid_d = 1'b0;
    step_c      = '0;
    pos_step_c  = position_q;
`ifdef QEI_INDEX_EN
    index_pos_d   = index_pos_q;
    index_valid_d = 1'b0;
    z_rise_c      = run_c && filt_q[2] && !prev_q[2];
`endif

    if (step_fwd_c) begin
      step_c     = ACC_W'(1);
      pos_step_c = position_q + CNT_W'(1);
      dir_d      = 1'b1;
    end else if (step_rev_c) begin
      step_c     = '1;
      pos_step_c = position_q - CNT_W'(1);
      dir_d      = 1'b0;
    end
    position_d = pos_step_c;

`ifdef QEI_INDEX_EN
    // Capture includes this cycle's step; the zeroing only affects position
    if (z_rise_c) begin
      index_pos_d   = pos_step_c;
      index_valid_d = 1'b1;
      if (index_reset) position_d = '0;
    end
`endif

    if (clr) position_d = '0;

    if (illegal_c)    err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;

    acc_sum_c = acc_q + step_c;
    if (win_q == WIN_W'(VEL_PERIOD - 1)) begin
      win_d       = '0;
      acc_d       = '0;
      vel_valid_d = 1'b1;
      if (acc_sum_c > VEL_MAX)      velocity_d = VEL_W'(VEL_MAX);
      else if (acc_sum_c < VEL_MIN) velocity_d = VEL_W'(VEL_MIN);
      else                          velocity_d = VEL_W'(acc_sum_c);
    end else begin
      acc_d = acc_sum_c;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SYNC1;
      s1_q        <= '0;
      s2_q        <= '0;
      filt_q      <= '0;
      prev_q      <= '0;
      for (int i = 0; i < int'(NPIN); i++) fcnt_q[i] <= '0;
      position_q  <= '0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      win_q       <= '0;
      acc_q       <= '0;
      velocity_q  <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      filt_q      <= filt_d;
      prev_q      <= prev_d;
      for (int i = 0; i < int'(NPIN); i++) fcnt_q[i] <= fcnt_d[i];
      position_q  <= position_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      win_q       <= win_d;
      acc_q       <= acc_d;
      velocity_q  <= velocity_d;
      vel_valid_q <= vel_valid_d;
    end
  end

`ifdef QEI_INDEX_EN
  // Index capture registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_pos_q   <= '0;
      index_valid_q <= 1'b0;
    end else begin
      index_pos_q   <= index_pos_d;
      index_valid_q <= index_valid_d;
    end
  end

  assign index_pos   = index_pos_q;
  assign index_valid = index_valid_q;
`else
  assign index_pos   = '0;
  assign index_valid = 1'b0;
`endif

  assign position  = position_q;
  assign dir       = dir_q;
  assign err       = err_q;
  assign velocity  = velocity_q;
  assign vel_valid = vel_valid_q;

endmodule

// File: tb/tb_qei_decoder.sv
// tb_qei_decoder: randomized and directed bench for qei_decoder against a
// step-table reference model (position, direction, error, windowed velocity).
module tb_qei_decoder;

  localparam int unsigned CNT_W      = 8;
  localparam int unsigned FILT_LEN   = 4;
  localparam int unsigned VEL_W      = 8;
  localparam int unsigned VEL_PERIOD = 1000;
  localparam int          F          = int'(FILT_LEN);
  localparam int          POS_MOD    = 1 << CNT_W;
  localparam int          VMAX       = (1 << (VEL_W - 1)) - 1;

  logic                    clk;
  logic                    reset_n;
  logic                    enc_a, enc_b, enc_z;
  logic                    clr, err_clr, index_reset;
  logic [CNT_W-1:0]        position;
  logic                    dir, err;
  logic signed [VEL_W-1:0] velocity;
  logic                    vel_valid;
  logic [CNT_W-1:0]        index_pos;
  logic                    index_valid;

  qei_decoder #(
    .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .VEL_W(VEL_W), .VEL_PERIOD(VEL_PERIOD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .clr(clr), .err_clr(err_clr), .index_reset(index_reset),
    .position(position), .dir(dir), .err(err), .velocity(velocity),
    .vel_valid(vel_valid), .index_pos(index_pos), .index_valid(index_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int          m_pos;
  bit          m_dir, m_err;
  logic [1:0]  m_ab;              // {A,B}
  int          vel_bin [int];     // net steps per velocity window
  int unsigned edge_n;            // clock edges since reset release

  always @(posedge clk or negedge reset_n)
    if (!reset_n) edge_n <= 0;
    else          edge_n <= edge_n + 1;

  function automatic logic [1:0] q_next(input logic [1:0] ab, input bit fwd);
    logic [1:0] seq [4];
    int idx;
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    idx = 0;
    for (int i = 0; i < 4; i++) if (seq[i] == ab) idx = i;
    return seq[(idx + (fwd ? 1 : 3)) % 4];
  endfunction

  function automatic int sat(input int v);
    if (v > VMAX)  return VMAX;
    if (v < -VMAX) return -VMAX;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_ab(input logic [1:0] ab);
    enc_a = ab[1];
    enc_b = ab[0];
  endtask

  // A clean change driven now lands in position FILT_LEN+3 edges later
  task automatic note_step(input int d);
    int u, w;
    u = int'(edge_n) + 3 + F;
    w = (u - 1) / int'(VEL_PERIOD);
    if (vel_bin.exists(w)) vel_bin[w] = vel_bin[w] + d;
    else                   vel_bin[w] = d;
    m_pos = (m_pos + d + POS_MOD) % POS_MOD;
    m_dir = (d > 0);
  endtask

  task automatic quad(input bit fwd, input int hold);
    m_ab = q_next(m_ab, fwd);
    drive_ab(m_ab);
    note_step(fwd ? 1 : -1);
    tick(hold);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pos"}, position, m_pos);
    check({tag, "_dir"}, dir, m_dir);
    check({tag, "_err"}, err, m_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pos"}, position, 0);
    check({tag, "_dir"}, dir, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_vel"}, velocity, 0);
    check({tag, "_vvalid"}, vel_valid, 0);
    check({tag, "_ipos"}, index_pos, 0);
    check({tag, "_ivalid"}, index_valid, 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    m_pos = 0;
  endtask

  // Velocity window monitor
  int mon_w, mon_e;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (edge_n != 0 && (edge_n % VEL_PERIOD) == 0) begin
        mon_w = int'(edge_n / VEL_PERIOD) - 1;
        mon_e = vel_bin.exists(mon_w) ? sat(vel_bin[mon_w]) : 0;
        check("vel_valid", vel_valid, 1);
        check("velocity", velocity, mon_e);
      end else if (vel_valid !== 1'b0) begin
        check("vel_valid_spurious", vel_valid, 0);
      end
`ifndef QEI_INDEX_EN
      if (index_valid !== 1'b0) check("index_valid_off", index_valid, 0);
`endif
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int act, hold, p0, d, seen;
  logic [1:0] b, mask;

  initial begin
    reset_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
    clr = 1'b0; err_clr = 1'b0; index_reset = 1'b0;
    m_ab = 2'b00; m_pos = 0; m_dir = 1'b0; m_err = 1'b0;
    #23;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick(6);
    check_state("primed");

    // Randomized steps, glitches, illegal jumps and error clears
    repeat (150) begin
      act  = int'($urandom_range(0, 9));
      hold = F + 3 + int'($urandom_range(0, 5));
      if (act <= 3) quad(1'b1, hold);
      else if (act <= 6) quad(1'b0, hold);
      else if (act == 7) begin
        mask = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
        drive_ab(m_ab ^ mask);
        tick(int'($urandom_range(1, F - 1)));
        drive_ab(m_ab);
        tick(hold);
      end else if (act == 8) begin
        m_ab = m_ab ^ 2'b11;
        drive_ab(m_ab);
        m_err = 1'b1;
        tick(hold);
      end else begin
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        m_err = 1'b0;
        tick(1);
      end
      check_state("rand");
    end

    // Forward 8 cycles then reverse 3 cycles, 10 clocks per state
    do_clr();
    check("clr_pos", position, 0);
    repeat (32) quad(1'b1, 10);
    check("fwd32_pos", position, 32);
    check("fwd32_dir", dir, 1);
    check("fwd32_err", err, m_err);
    repeat (12) quad(1'b0, 10);
    check("rev12_pos", position, 20);
    check("rev12_dir", dir, 0);

    // Wrap both ways
    do_clr();
    quad(1'b0, F + 3);
    check("wrap_rev", position, POS_MOD - 1);
    quad(1'b1, F + 3);
    check("wrap_fwd", position, 0);

    // Filter: short pulse rejected, FILT_LEN pulse accepted with exact latency
    while (m_ab[1]) quad(1'b1, F + 3);
    p0 = m_pos;
    b  = m_ab;
    drive_ab(b | 2'b10);
    tick(F - 1);
    drive_ab(b);
    tick(F + 4);
    check("filt_short", position, p0);
    d = (q_next(b, 1'b1) == (b | 2'b10)) ? 1 : -1;
    m_ab = b | 2'b10;
    drive_ab(m_ab);
    note_step(d);
    tick(F);
    m_ab = b;
    drive_ab(m_ab);
    note_step(-d);
    tick(2);
    check("filt_lat_early", position, p0);
    tick(1);
    check("filt_lat_edge", position, (p0 + d + POS_MOD) % POS_MOD);
    tick(F + 4);
    check_state("filt_done");

    // Illegal jump, error clear, and set winning over clear
    p0 = m_pos;
    m_ab = m_ab ^ 2'b11;
    drive_ab(m_ab);
    tick(F + 3);
    m_err = 1'b1;
    check_state("illegal");
    check("illegal_pos", position, p0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_err = 1'b0;
    check("err_clr", err, 0);
    m_ab = m_ab ^ 2'b11;
    drive_ab(m_ab);
    tick(F + 2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_err = 1'b1;
    check("err_prio", err, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_err = 1'b0;

    // Clear on the same cycle as a step
    m_ab = q_next(m_ab, 1'b1);
    drive_ab(m_ab);
    note_step(1);
    tick(F + 2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    m_pos = 0;
    check("clr_prio", position, 0);
    quad(1'b1, F + 3);
    check_state("after_clr");

    // Reset mid-operation with pins parked at 11
    while (m_ab != 2'b11) quad(1'b1, F + 3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    #10;
    reset_n = 1'b1;
    m_pos = 0; m_dir = 1'b0; m_err = 1'b0;
    vel_bin.delete();
    tick(6);
    check_state("post_reset");

    // Velocity: one step every 50 clocks gives 20 per 1000-clock window
    seen = 0;
    repeat (80) begin
      quad(1'b1, 1);
      repeat (49) begin
        if (vel_valid === 1'b1 && edge_n <= 4000) begin
          check("vel20", velocity, 20);
          seen++;
        end
        tick(1);
      end
    end
    check("vel20_windows", (seen >= 3) ? 1 : 0, 1);

    // Saturation both ways: a step every 5 clocks exceeds VMAX per window
    repeat (400) quad(1'b1, 5);
    repeat (400) quad(1'b0, 5);
    tick(F + 3);
    check_state("sat_done");

`ifdef QEI_INDEX_EN
    do_clr();
    repeat (37) quad(1'b1, F + 3);
    check("idx_setup", position, 37);
    enc_z = 1'b1;
    tick(F + 2);
    check("idx_early", index_valid, 0);
    tick(1);
    check("idx_valid", index_valid, 1);
    check("idx_pos", index_pos, 37);
    check("idx_keep_pos", position, 37);
    tick(1);
    check("idx_pulse_end", index_valid, 0);
    enc_z = 1'b0;
    tick(F + 4);
    index_reset = 1'b1;
    enc_z = 1'b1;
    tick(F + 3);
    m_pos = 0;
    check("idxr_valid", index_valid, 1);
    check("idxr_pos", index_pos, 37);
    check("idxr_zero", position, 0);
    index_reset = 1'b0;
    enc_z = 1'b0;
    tick(F + 4);
    check_state("idx_done");
`else
    p0 = m_pos;
    enc_z = 1'b1;
    index_reset = 1'b1;
    tick(F + 3);
    check("noidx_valid", index_valid, 0);
    check("noidx_ipos", index_pos, 0);
    check("noidx_pos", position, p0);
    enc_z = 1'b0;
    index_reset = 1'b0;
    tick(F + 4);
    check_state("noidx_done");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
